uart_tx_fifo: RTL and testbench

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the register/bus side and presents them to the UART over the txData/txDataReady/txDataRead handshake. It decouples software writes from the baud-rate-paced serialiser and signals when the buffer has drained.

---
 rtl/uart_tx_fifo_if.sv | 20 ++
 rtl/uart_tx_fifo.sv | 80 ++++++++
 tb/tb_uart_tx_fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the bus writer / UART serialiser (master) and the TX FIFO (slave).
// Write side: wrData/wrValid/wrReady. Read side: txData/txDataReady/txDataRead.
interface uart_tx_fifo_if;
  logic [7:0] wrData;
  logic       wrValid;
  logic       wrReady;
  logic [7:0] txData;
  logic       txDataReady;
  logic       txDataRead;

  modport master (
    output wrData, wrValid, txDataRead,
    input  wrReady, txData, txDataReady
  );

  modport slave (
    input  wrData, wrValid, txDataRead,
    output wrReady, txData, txDataReady
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead circular byte buffer feeding the UART transmitter.
// Drain detection produces eventReadyTx; overflow is a sticky flag for rejected writes.
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          ck,
  input  logic          arst_n,
  input  logic          uartTxEnable,
  uart_tx_fifo_if.slave bus,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          eventReadyTx,
  output logic          overflow,
  input  logic          overflowClr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign level = cnt;
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  assign bus.wrReady     = !full  && uartTxEnable;
  assign bus.txDataReady = !empty && uartTxEnable;
  assign bus.txData      = mem[rp];

  // Handshakes qualified only by registered readies, so a full FIFO rejects a push even when popping.
  assign push = bus.wrValid    && bus.wrReady;
  assign pop  = bus.txDataRead && bus.txDataReady;

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      eventReadyTx <= 1'b0;
    end else if (!uartTxEnable) begin
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      eventReadyTx <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      eventReadyTx <= pop && !push && (cnt == ONE_CNT);
    end
  end

  // Set has priority over clear; a disabled path never flags overflow.
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      overflow <= 1'b0;
    end else if (bus.wrValid && full && uartTxEnable) begin
      overflow <= 1'b1;
    end else if (overflowClr) begin
      overflow <= 1'b0;
    end
  end

  // NOTE: storage is deliberately left unreset; contents are only read behind a valid count.
  always_ff @(posedge ck) begin
    if (push) mem[wp] <= bus.wrData;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based model of the buffer.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;

  logic       ck = 1'b0;
  logic       arst_n;
  logic       en;
  logic       clr;
  logic [3:0] level;
  logic       full, empty, ev, ovf;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .ck(ck), .arst_n(arst_n), .uartTxEnable(en), .bus(bus),
    .level(level), .full(full), .empty(empty),
    .eventReadyTx(ev), .overflow(ovf), .overflowClr(clr)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO contents, sticky overflow, expected drain pulse.
  logic [7:0] q [$];
  bit         m_ovf;
  bit         m_ev;

  // Drive one clock cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic cycle(input bit wv, input logic [7:0] wd, input bit rd, input bit c);
    int n;
    bit popped;
    bus.wrValid    = wv;
    bus.wrData     = wd;
    bus.txDataRead = rd;
    clr            = c;
    n      = q.size();
    popped = 0;
    if (wv && en && n == DEPTH) m_ovf = 1;
    else if (c)                 m_ovf = 0;
    if (en) begin
      if (rd && n > 0) begin
        void'(q.pop_front());
        popped = 1;
      end
      if (wv && n < DEPTH) q.push_back(wd);
      m_ev = popped && (q.size() == 0);
    end else begin
      q.delete();
      m_ev = 0;
    end
    @(posedge ck);
    #1;
    bus.wrValid    = 1'b0;
    bus.txDataRead = 1'b0;
    clr            = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    en     = 1'b0;
    #12;
    n_checks++; if (level !== 4'd0) $display("FAIL reset_level got=%0d exp=0", level); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
    n_checks++; if (bus.wrReady !== 1'b0) $display("FAIL reset_wrready got=%b exp=0", bus.wrReady); else n_pass++;
    n_checks++; if (bus.txDataReady !== 1'b0) $display("FAIL reset_txready got=%b exp=0", bus.txDataReady); else n_pass++;
    n_checks++; if (ev !== 1'b0) $display("FAIL reset_event got=%b exp=0", ev); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", ovf); else n_pass++;
    @(negedge ck);
    arst_n = 1'b1;
    en     = 1'b1;
    cycle(0, 8'h00, 0, 0);
    n_checks++; if (bus.wrReady !== 1'b1) $display("FAIL reset_release_wrready got=%b exp=1", bus.wrReady); else n_pass++;
  endtask

  task automatic test_order_wrap();
    int ev_count;
    ev_count = 0;
    for (int k = 0; k < 6; k++) cycle(1, 8'(8'h11 + k), 0, 0);
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (bus.txData !== 8'(8'h11 + k)) $display("FAIL wrap_data[%0d] got=%h exp=%h", k, bus.txData, 8'(8'h11 + k)); else n_pass++;
      cycle(1, 8'(8'h17 + k), 1, 0);
      ev_count += int'(ev);
      n_checks++; if (level !== 4'd6) $display("FAIL wrap_level[%0d] got=%0d exp=6", k, level); else n_pass++;
    end
    for (int k = 6; k < 12; k++) begin
      n_checks++; if (bus.txData !== 8'(8'h11 + k)) $display("FAIL wrap_data[%0d] got=%h exp=%h", k, bus.txData, 8'(8'h11 + k)); else n_pass++;
      cycle(0, 8'h00, 1, 0);
      ev_count += int'(ev);
    end
    n_checks++; if (ev !== 1'b1) $display("FAIL wrap_final_event got=%b exp=1", ev); else n_pass++;
    n_checks++; if (ev_count != 1) $display("FAIL wrap_event_count got=%0d exp=1", ev_count); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL wrap_empty got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_full_overflow();
    logic [7:0] exp_b [DEPTH];
    for (int k = 0; k < DEPTH; k++) begin
      exp_b[k] = 8'($urandom_range(0, 8'h7F));
      cycle(1, exp_b[k], 0, 0);
    end
    n_checks++; if (full !== 1'b1) $display("FAIL full_flag got=%b exp=1", full); else n_pass++;
    n_checks++; if (bus.wrReady !== 1'b0) $display("FAIL full_wrready got=%b exp=0", bus.wrReady); else n_pass++;
    n_checks++; if (level !== 4'd8) $display("FAIL full_level got=%0d exp=8", level); else n_pass++;
    cycle(1, 8'hAA, 0, 0);
    n_checks++; if (ovf !== 1'b1) $display("FAIL overflow_set got=%b exp=1", ovf); else n_pass++;
    n_checks++; if (level !== 4'd8) $display("FAIL overflow_level got=%0d exp=8", level); else n_pass++;
    cycle(0, 8'h00, 0, 1);
    n_checks++; if (ovf !== 1'b0) $display("FAIL overflow_clear got=%b exp=0", ovf); else n_pass++;
    cycle(1, 8'hAA, 0, 1);
    n_checks++; if (ovf !== 1'b1) $display("FAIL overflow_set_wins got=%b exp=1", ovf); else n_pass++;
    cycle(1, 8'hAA, 1, 0);
    n_checks++; if (level !== 4'd7) $display("FAIL full_pushpop_level got=%0d exp=7", level); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL full_pushpop_overflow got=%b exp=1", ovf); else n_pass++;
    for (int k = 1; k < DEPTH; k++) begin
      n_checks++; if (bus.txData !== exp_b[k]) $display("FAIL full_drain[%0d] got=%h exp=%h", k, bus.txData, exp_b[k]); else n_pass++;
      cycle(0, 8'h00, 1, 0);
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL full_drain_empty got=%b exp=1", empty); else n_pass++;
    cycle(0, 8'h00, 0, 1);
    n_checks++; if (ovf !== 1'b0) $display("FAIL full_final_clear got=%b exp=0", ovf); else n_pass++;
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) cycle(1, 8'(8'h30 + k), 0, 0);
    cycle(1, 8'h33, 1, 0);
    n_checks++; if (level !== 4'd3) $display("FAIL simul_level3 got=%0d exp=3", level); else n_pass++;
    n_checks++; if (bus.txData !== 8'h31) $display("FAIL simul_head got=%h exp=31", bus.txData); else n_pass++;
    for (int k = 0; k < 3; k++) cycle(0, 8'h00, 1, 0);
    cycle(1, 8'h5C, 1, 0);
    n_checks++; if (level !== 4'd1) $display("FAIL simul_empty_level got=%0d exp=1", level); else n_pass++;
    n_checks++; if (bus.txData !== 8'h5C) $display("FAIL simul_empty_data got=%h exp=5c", bus.txData); else n_pass++;
    n_checks++; if (ev !== 1'b0) $display("FAIL simul_empty_event got=%b exp=0", ev); else n_pass++;
    cycle(0, 8'h00, 1, 0);
    n_checks++; if (ev !== 1'b1) $display("FAIL simul_drain_event got=%b exp=1", ev); else n_pass++;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 6; k++) cycle(1, 8'($urandom), 0, 0);
    en = 1'b0;
    cycle(1, 8'h77, 1, 0);
    n_checks++; if (level !== 4'd0) $display("FAIL flush_level got=%0d exp=0", level); else n_pass++;
    n_checks++; if (bus.txDataReady !== 1'b0) $display("FAIL flush_txready got=%b exp=0", bus.txDataReady); else n_pass++;
    n_checks++; if (bus.wrReady !== 1'b0) $display("FAIL flush_wrready got=%b exp=0", bus.wrReady); else n_pass++;
    n_checks++; if (ev !== 1'b0) $display("FAIL flush_event got=%b exp=0", ev); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL flush_overflow got=%b exp=0", ovf); else n_pass++;
    en = 1'b1;
    cycle(0, 8'h00, 0, 0);
    n_checks++; if (empty !== 1'b1) $display("FAIL flush_after_empty got=%b exp=1", empty); else n_pass++;
    n_checks++; if (ev !== 1'b0) $display("FAIL flush_after_event got=%b exp=0", ev); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) begin
      b[k] = 8'(8'h40 + 16 * k + $urandom_range(0, 15));
      cycle(1, b[k], 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.txData !== b[k]) $display("FAIL b2b_data[%0d] got=%h exp=%h", k, bus.txData, b[k]); else n_pass++;
      cycle(0, 8'h00, 1, 0);
      if (k == 2) begin
        n_checks++; if (ev !== 1'b0) $display("FAIL b2b_early_event got=%b exp=0", ev); else n_pass++;
      end
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL b2b_empty got=%b exp=1", empty); else n_pass++;
    n_checks++; if (ev !== 1'b1) $display("FAIL b2b_event got=%b exp=1", ev); else n_pass++;
    cycle(0, 8'h00, 0, 0);
    n_checks++; if (ev !== 1'b0) $display("FAIL b2b_event_width got=%b exp=0", ev); else n_pass++;
  endtask

  task automatic test_random();
    bit         wv, rd, c;
    logic [7:0] d;
    int         bias;
    for (int i = 0; i < 400; i++) begin
      bias = ((i % 200) < 100) ? 70 : 30;
      en   = ($urandom_range(0, 24) != 0);
      wv   = ($urandom_range(0, 99) < bias);
      rd   = ($urandom_range(0, 99) < (100 - bias));
      c    = ($urandom_range(0, 9) == 0);
      d    = 8'($urandom);
      cycle(wv, d, rd, c);
      n_checks++; if (level !== 4'(q.size())) $display("FAIL rand_level[%0d] got=%0d exp=%0d", i, level, q.size()); else n_pass++;
      n_checks++; if (ev !== m_ev) $display("FAIL rand_event[%0d] got=%b exp=%b", i, ev, m_ev); else n_pass++;
      n_checks++; if (ovf !== m_ovf) $display("FAIL rand_overflow[%0d] got=%b exp=%b", i, ovf, m_ovf); else n_pass++;
      n_checks++; if (bus.txDataReady !== ((q.size() != 0) && en)) $display("FAIL rand_txready[%0d] got=%b exp=%b", i, bus.txDataReady, (q.size() != 0) && en); else n_pass++;
      n_checks++; if (bus.wrReady !== ((q.size() < DEPTH) && en)) $display("FAIL rand_wrready[%0d] got=%b exp=%b", i, bus.wrReady, (q.size() < DEPTH) && en); else n_pass++;
      if (q.size() != 0) begin
        n_checks++; if (bus.txData !== q[0]) $display("FAIL rand_data[%0d] got=%h exp=%h", i, bus.txData, q[0]); else n_pass++;
      end
    end
    en = 1'b1;
    while (q.size() != 0) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < DEPTH; k++) cycle(1, 8'(k), 0, 0);
    cycle(1, 8'hAA, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 8'h00, 1, 0);
    n_checks++; if (level !== 4'd5) $display("FAIL midreset_pre_level got=%0d exp=5", level); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL midreset_pre_overflow got=%b exp=1", ovf); else n_pass++;
    @(negedge ck);
    arst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 0;
    m_ev  = 0;
    n_checks++; if (level !== 4'd0) $display("FAIL midreset_level got=%0d exp=0", level); else n_pass++;
    n_checks++; if (bus.txDataReady !== 1'b0) $display("FAIL midreset_txready got=%b exp=0", bus.txDataReady); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL midreset_overflow got=%b exp=0", ovf); else n_pass++;
    @(negedge ck);
    arst_n = 1'b1;
    cycle(0, 8'h00, 0, 0);
    n_checks++; if (bus.wrReady !== 1'b1) $display("FAIL midreset_release_wrready got=%b exp=1", bus.wrReady); else n_pass++;
    n_checks++; if (ev !== 1'b0) $display("FAIL midreset_event got=%b exp=0", ev); else n_pass++;
  endtask

  initial begin
    bus.wrValid    = 1'b0;
    bus.wrData     = 8'h00;
    bus.txDataRead = 1'b0;
    clr            = 1'b0;
    m_ovf          = 0;
    m_ev           = 0;
    test_reset();
    test_order_wrap();
    test_full_overflow();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
